// File: rtl/sp_bank_fifo.sv
// sp_bank_fifo -- multi-channel scratchpad queue.
//
// One shared write port (wen/wch/wdata) feeds NUM_CH independent circular
// FIFOs, one per bank. Each channel has its own show-ahead read port, flush,
// almost-full, occupancy and sticky overflow/underflow flags.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   wen, wch, wdata    write request, target channel, entry
//   ren[NUM_CH]        per-channel pop of the head entry
//   flush[NUM_CH]      per-channel synchronous clear (wins over push/pop)
//   rvalid, rdata      per-channel head valid / head entry (0 when empty);
//                      channel c at rdata[c*DATA_W +: DATA_W]
//   full, afull, count per-channel status; count packed like rdata
//   ovf, udf           per-channel sticky overflow / underflow
//
// Optional feature macro: SP_BANK_FIFO_BYPASS_EN
//   When defined, a write to an empty channel is visible on rvalid/rdata in
//   the same cycle, and a same-cycle pop consumes it without storing it.
//   When undefined, outputs depend on registered state only.

// Single channel: wrap-bit pointers over a DEPTH-entry circular buffer.
module sp_bank_fifo_ch #(
    parameter int DATA_W   = 71,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int PTR_W   = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop_req,
    input  logic              flush,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              afull,
    output logic [PTR_W-1:0]  count,
    output logic              ovf,
    output logic              udf
);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic empty, is_full, bypass, do_push;

    assign empty   = (wptr_q == rptr_q);
    // Same slot, opposite lap: writer is one full lap ahead of the reader.
    assign is_full = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                     (wptr_q[IDX_W] != rptr_q[IDX_W]);

`ifdef SP_BANK_FIFO_BYPASS_EN
    // Gated by reset so that outputs read as zero while nRST is held.
    assign bypass = rst_n && empty && push_req && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        do_push = 1'b0;
        if (flush) begin
            // Any same-cycle push/pop to this channel is discarded silently.
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else if (bypass && pop_req) begin
            // Entry passes straight through to the reader; nothing stored.
        end else begin
            if (pop_req) begin
                if (empty) udf_d  = 1'b1;
                else       rptr_d = rptr_q + PTR_W'(1);
            end
            if (push_req) begin
                // A full channel still accepts when the head leaves this cycle.
                if (is_full && !pop_req) begin
                    ovf_d = 1'b1;
                end else begin
                    do_push = 1'b1;
                    wptr_d  = wptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Storage is not reset; empty slots are never observable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[IDX_W-1:0]] <= wdata;
    end

    assign count  = wptr_q - rptr_q;
    assign full   = is_full;
    assign afull  = (count >= PTR_W'(AFULL_TH));
    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign rvalid = !empty || bypass;
    assign rdata  = !empty ? mem[rptr_q[IDX_W-1:0]] :
                    (bypass ? wdata : '0);

endmodule

module sp_bank_fifo #(
    parameter int DATA_W   = 71,
    parameter int DEPTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int AFULL_TH = 6,
    localparam int CH_W    = $clog2(NUM_CH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     wen,
    input  logic [CH_W-1:0]          wch,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_CH-1:0]        ren,
    input  logic [NUM_CH-1:0]        flush,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [NUM_CH*DATA_W-1:0] rdata,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        afull,
    output logic [NUM_CH*CNT_W-1:0]  count,
    output logic [NUM_CH-1:0]        ovf,
    output logic [NUM_CH-1:0]        udf
);

    logic [NUM_CH-1:0] ch_push;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_push[c] = wen && (wch == CH_W'(c));

        sp_bank_fifo_ch #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .AFULL_TH (AFULL_TH)
        ) u_ch (
            .clk      (CLK),
            .rst_n    (nRST),
            .push_req (ch_push[c]),
            .wdata    (wdata),
            .pop_req  (ren[c]),
            .flush    (flush[c]),
            .rvalid   (rvalid[c]),
            .rdata    (rdata[c*DATA_W +: DATA_W]),
            .full     (full[c]),
            .afull    (afull[c]),
            .count    (count[c*CNT_W +: CNT_W]),
            .ovf      (ovf[c]),
            .udf      (udf[c])
        );
    end

endmodule
